// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and counter sizing for the key event front end
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DB_PR   = 3'd1,
        ST_PRESSED = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DB_REL  = 3'd4
    } key_state_e;

    // Width needed to hold the largest tick interval any state compares against.
    function automatic int cnt_width(input int deb_ms, input int long_ms, input int rep_ms);
        int m;
        m = deb_ms;
        if (long_ms > m) m = long_ms;
        if (rep_ms > m) m = rep_ms;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_event_chan.sv
// rtl/key_event_chan.sv - one key channel: synchroniser, debounce FSM and event pulses
module key_event_chan
    import key_pkg::*;
#(
    parameter int DEB_MS     = 20,
    parameter int LONG_MS    = 1000,
    parameter int REP_MS     = 200,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int CW = cnt_width(DEB_MS, LONG_MS, REP_MS);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_MS - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'((LONG_MS != 0) ? LONG_MS - 1 : 0);
    localparam logic [CW-1:0] REP_LAST  = CW'((REP_MS != 0) ? REP_MS - 1 : 0);
    localparam logic          REL_LEVEL = ACTIVE_LOW;

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            raw;
    key_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            long_done_q, long_done_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            long_q, long_d;
    logic            rep_q, rep_d;

    assign raw     = sync2_q ^ ACTIVE_LOW;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
    end

    // Compare against the last value before incrementing so the exit happens on the
    // tick that makes the count reach its target; cnt never needs to hold that value.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        long_d      = 1'b0;
        rep_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                long_done_d = 1'b0;
                if (raw) begin
                    state_d = ST_DB_PR;
                    cnt_d   = '0;
                end
            end
            ST_DB_PR: begin
                if (!raw) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                        level_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_PRESSED: begin
                if (!raw) begin
                    state_d = ST_DB_REL;
                    cnt_d   = '0;
                end else if (tick && (LONG_MS != 0)) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d     = ST_HOLD;
                        cnt_d       = '0;
                        long_d      = !long_done_q;
                        long_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_HOLD: begin
                if (!raw) begin
                    state_d = ST_DB_REL;
                    cnt_d   = '0;
                end else if (tick && (REP_MS != 0)) begin
                    if (cnt_q == REP_LAST) begin
                        cnt_d = '0;
                        rep_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_DB_REL: begin
                // A bounce back to pressed keeps long_done so the hold is not re-announced.
                if (raw) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        rel_d   = 1'b1;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q     <= REL_LEVEL;
            sync2_q     <= REL_LEVEL;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            long_q      <= 1'b0;
            rep_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            long_q      <= long_d;
            rep_q       <= rep_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = rel_q;
    assign key_long    = long_q;
    assign key_repeat  = rep_q;

endmodule

// File: rtl/key_event_n.sv
// rtl/key_event_n.sv - N-channel push-button front end sharing one tick timebase
module key_event_n
    import key_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int DEB_MS     = 20,
    parameter int LONG_MS    = 1000,
    parameter int REP_MS     = 200,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_event_chan #(
            .DEB_MS     (DEB_MS),
            .LONG_MS    (LONG_MS),
            .REP_MS     (REP_MS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .clk         (clk),
            .rstn        (rstn),
            .tick        (tick),
            .key_in      (key_in[g]),
            .key_level   (key_level[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g]),
            .key_repeat  (key_repeat[g])
        );
    end

endmodule
